button_debouncer: RTL and testbench

Conditions raw active-low push-button inputs from the PMOD header into clean, clock-synchronous events. Each channel is synchronised into the `clk` domain, then debounced by a per-channel counter and state machine. The block emits a debounced level plus single-cycle press and release pulses. It sits directly upstream of the button counter, whose increment enable and clear inputs are driven by `press`, instead of wiring buttons straight to clock or reset pins.

---
 rtl/button_debouncer.sv | 149 ++++++++++++++
 tb/tb_button_debouncer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// This block takes raw push-button inputs, which are active-low, asynchronous
// and bouncy. It turns them into clean events in the clk domain. Each channel
// has its own path: a two-flop synchroniser, a debounce counter and a
// four-state FSM. Channels never interact.
//
// Outputs per channel:
//   - level:         the debounced pressed state.
//   - press:         a one-cycle pulse when a press is accepted.
//   - release_pulse: a one-cycle pulse when a release is accepted.
//
// All outputs come from registers. No path runs from input to output
// through logic alone.
//
// The release output is named release_pulse because "release" is a
// reserved word in SystemVerilog (force/release).
//
// Parameters:
//   NUM_BTN          number of button channels (>= 1)
//   DEBOUNCE_CYCLES  cycles the synchronised input must hold a new value
//                    before it is accepted (>= 2)
//
// Ports:
//   clk            in   1        system clock
//   rst            in   1        asynchronous, active-high reset
//   btn_n          in   NUM_BTN  raw buttons, active-low, asynchronous
//   level          out  NUM_BTN  debounced state, 1 = pressed
//   press          out  NUM_BTN  one-cycle pulse on accepted press
//   release_pulse  out  NUM_BTN  one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic             s;
      state_t           state_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             press_reg;
      logic             release_reg;

      // The synchroniser resets to "not pressed". A button held through
      // reset therefore looks like a fresh press once reset is released.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= btn_n[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign s = ~sync2_reg;

      // The counter is cleared on every state entry. It is only compared
      // against CNT_LAST and never increments past it, so it cannot wrap.
      // The level register changes on the same edge as the accepting
      // transition, so level and its pulse line up.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          case (state_reg)
            IDLE: begin
              if (s) begin
                state_reg <= ARM_PRESS;
                cnt_reg   <= '0;
              end
            end
            ARM_PRESS: begin
              if (!s) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= HELD;
                cnt_reg   <= '0;
                level_reg <= 1'b1;
                press_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            HELD: begin
              if (!s) begin
                state_reg <= ARM_RELEASE;
                cnt_reg   <= '0;
              end
            end
            ARM_RELEASE: begin
              if (s) begin
                state_reg <= HELD;
                cnt_reg   <= '0;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg   <= IDLE;
                cnt_reg     <= '0;
                level_reg   <= 1'b0;
                release_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            default: begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              level_reg <= 1'b0;
            end
          endcase
        end
      end

      assign level[gi]         = level_reg;
      assign press[gi]         = press_reg;
      assign release_pulse[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with NUM_BTN=2 and
// DEBOUNCE_CYCLES=4.
//
// Inputs are driven 1 time unit after each rising edge. The first rising
// edge after a drive is "edge 0" for that input value. Outputs are sampled
// 1 time unit after each edge.
//
// For each cycle, the expected output vector is pushed onto a queue when
// that cycle's stimulus is driven. It is popped and compared once the DUT
// has clocked.
//
// Packed expectation: {level[1:0], press[1:0], release[1:0]}.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int LAT = DC + 2;  // edge index after which an accepted event appears

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] level;
  logic [NB-1:0] press;
  logic [NB-1:0] release_pulse;

  logic [5:0] exp_q[$];
  logic [5:0] exp_v;
  logic [5:0] obs_v;
  int vectors = 0;
  int miscompares = 0;

  button_debouncer #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .level(level),
    .press(press),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_n = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(6'b00_00_00);
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_held k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("reset_held k=%0d outputs=%b ok", k, obs_v);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(6'b00_00_00);
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("reset_idle k=%0d outputs=%b ok", k, obs_v);
    end
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b10;
      exp_q.push_back({(k >= LAT) ? 2'b01 : 2'b00, (k == LAT) ? 2'b01 : 2'b00, 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL clean_press k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("clean_press k=%0d outputs=%b ok", k, obs_v);
    end
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b11;
      exp_q.push_back({(k < LAT) ? 2'b01 : 2'b00, 2'b00, (k == LAT) ? 2'b01 : 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL clean_release k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("clean_release k=%0d outputs=%b ok", k, obs_v);
    end
  endtask

  // Channel 1 input: low 1, high 2, low 2, high 2, low 3, high 2, then
  // held low from index 12 (the final low onset).
  task automatic test_bounce();
    logic b1;
    for (int k = 0; k < 24; k++) begin
      b1 = (k == 0 || k == 3 || k == 4 || (k >= 7 && k <= 9) || k >= 12) ? 1'b0 : 1'b1;
      btn_n = {b1, 1'b1};
      exp_q.push_back({(k >= 12 + LAT) ? 2'b10 : 2'b00, (k == 12 + LAT) ? 2'b10 : 2'b00, 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL bounce k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("bounce k=%0d outputs=%b ok", k, obs_v);
    end
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b11;
      exp_q.push_back({(k < LAT) ? 2'b10 : 2'b00, 2'b00, (k == LAT) ? 2'b10 : 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL bounce_release k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("bounce_release k=%0d outputs=%b ok", k, obs_v);
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b00;
      exp_q.push_back({(k >= LAT) ? 2'b11 : 2'b00, (k == LAT) ? 2'b11 : 2'b00, 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL simul_press k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("simul_press k=%0d outputs=%b ok", k, obs_v);
    end
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b11;
      exp_q.push_back({(k < LAT) ? 2'b11 : 2'b00, 2'b00, (k == LAT) ? 2'b11 : 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL simul_release k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("simul_release k=%0d outputs=%b ok", k, obs_v);
    end
  endtask

  // Reset is first applied while channel 0 is part-way through ARM_PRESS.
  // It is applied again while channel 0 is held. Both times the button stays
  // down, so a new press is expected at the normal latency after reset.
  task automatic test_reset_mid_operation();
    for (int pass = 0; pass < 2; pass++) begin
      // Pass 0: edges 0..4 bring channel 0 to ARM_PRESS with cnt=2.
      // Pass 1: channel 0 is already held, so just check it stays held.
      for (int k = 0; k < 5; k++) begin
        btn_n = 2'b10;
        exp_q.push_back((pass == 0) ? 6'b00_00_00 : 6'b01_00_00);
        tick();
        exp_v = exp_q.pop_front();
        obs_v = {level, press, release_pulse};
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("FAIL rst_mid_pre p=%0d k=%0d observed=%b required=%b", pass, k, obs_v, exp_v);
        end else $display("rst_mid_pre p=%0d k=%0d outputs=%b ok", pass, k, obs_v);
      end
      rst = 1'b1;
      exp_q.push_back(6'b00_00_00);
      #1;
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rst_mid_async p=%0d observed=%b required=%b", pass, obs_v, exp_v);
      end else $display("rst_mid_async p=%0d outputs=%b ok", pass, obs_v);
      exp_q.push_back(6'b00_00_00);
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rst_mid_during p=%0d observed=%b required=%b", pass, obs_v, exp_v);
      end else $display("rst_mid_during p=%0d outputs=%b ok", pass, obs_v);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
        btn_n = 2'b10;
        exp_q.push_back({(k >= LAT) ? 2'b01 : 2'b00, (k == LAT) ? 2'b01 : 2'b00, 2'b00});
        tick();
        exp_v = exp_q.pop_front();
        obs_v = {level, press, release_pulse};
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("FAIL rst_mid_repress p=%0d k=%0d observed=%b required=%b", pass, k, obs_v, exp_v);
        end else $display("rst_mid_repress p=%0d k=%0d outputs=%b ok", pass, k, obs_v);
      end
    end
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b11;
      exp_q.push_back({(k < LAT) ? 2'b01 : 2'b00, 2'b00, (k == LAT) ? 2'b01 : 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rst_mid_release k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("rst_mid_release k=%0d outputs=%b ok", k, obs_v);
    end
  endtask

  task automatic test_release_glitch();
    for (int k = 0; k < 8; k++) begin
      btn_n = 2'b10;
      exp_q.push_back({(k >= LAT) ? 2'b01 : 2'b00, (k == LAT) ? 2'b01 : 2'b00, 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL glitch_press k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("glitch_press k=%0d outputs=%b ok", k, obs_v);
    end
    // A 3-cycle high pulse is shorter than the debounce window, so it must
    // be absorbed.
    for (int k = 0; k < 12; k++) begin
      btn_n = (k < 3) ? 2'b11 : 2'b10;
      exp_q.push_back(6'b01_00_00);
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL glitch_held k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("glitch_held k=%0d outputs=%b ok", k, obs_v);
    end
    for (int k = 0; k < 12; k++) begin
      btn_n = 2'b11;
      exp_q.push_back({(k < LAT) ? 2'b01 : 2'b00, 2'b00, (k == LAT) ? 2'b01 : 2'b00});
      tick();
      exp_v = exp_q.pop_front();
      obs_v = {level, press, release_pulse};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL glitch_release k=%0d observed=%b required=%b", k, obs_v, exp_v);
      end else $display("glitch_release k=%0d outputs=%b ok", k, obs_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_n = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_operation();
    test_release_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
